// File: rtl/wb_cmd_master.sv
// Wishbone classic master: turns a ready/valid command into single-beat or
// incrementing-burst bus cycles, with one response per beat and a per-beat ack timeout.
module wb_cmd_master #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [3:0]  cmd_len_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state, state_d;
    logic [3:0]           beat_cnt, beat_cnt_d;
    logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_d;
    logic                 we_q, we_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [3:0]           sel_q, sel_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_last_q, rsp_last_d;

    // Next-state and next-output logic; every bus-facing output is a flop.
    always_comb begin
        state_d     = state;
        beat_cnt_d  = beat_cnt;
        wait_cnt_d  = wait_cnt;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = 32'h0;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d       = cmd_we_i;
                    adr_d      = cmd_adr_i;
                    dat_d      = cmd_we_i ? cmd_dat_i : 32'h0;
                    sel_d      = cmd_sel_i;
                    beat_cnt_d = cmd_len_i;
                    wait_cnt_d = '0;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (wbm_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (beat_cnt == 4'd0);
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    stb_d       = 1'b0;
                    if (beat_cnt == 4'd0) begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt - 4'd1;
                        adr_d      = adr_q + 32'd4;
                        state_d    = GAP;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    // Timeout abandons the remaining beats of the burst.
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            GAP: begin
                stb_d      = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            beat_cnt    <= 4'd0;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            sel_q       <= 4'h0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state       <= state_d;
            beat_cnt    <= beat_cnt_d;
            wait_cnt    <= wait_cnt_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Ready is gated by the reset input so nothing is accepted while reset is held.
    assign cmd_ready_o = (state == IDLE) && wb_rst_n_i;
    assign busy_o      = (state != IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a programmable-latency slave model;
// one task per scenario, each with its own inline expectations.
module tb_wb_cmd_master;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel, cmd_len;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack;
    logic        rsp_valid, rsp_err, rsp_last, busy;
    logic [31:0] rsp_dat;

    int          total = 0;
    int          bad   = 0;

    // Slave: acks combinationally once stb has been high for slave_wait cycles.
    int          slave_wait = 0;
    logic [31:0] rd_data = 32'h0;
    logic [7:0]  slv_cnt = 8'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!stb) slv_cnt <= 8'd0;
        else      slv_cnt <= slv_cnt + 8'd1;
    end

    assign ack   = stb && (int'(slv_cnt) == slave_wait);
    assign dat_i = rd_data;

    wb_cmd_master #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .cmd_len_i   (cmd_len),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_sel_o   (sel),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (dat_i),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .rsp_last_o  (rsp_last),
        .busy_o      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a command for one edge; returns in the cycle after acceptance.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [3:0] l);
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        cmd_len   = l;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if ({cyc, stb, we, busy, rsp_valid, rsp_err, rsp_last, cmd_ready} !== 8'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=00000000",
                     {cyc, stb, we, busy, rsp_valid, rsp_err, rsp_last, cmd_ready});
        end
        total++;
        if ({adr, dat_o, sel, rsp_dat} !== 100'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h want=0", {adr, dat_o, sel, rsp_dat});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_ready got=%b want=1", cmd_ready);
        end
    endtask

    task automatic test_single_read();
        slave_wait = 0;
        rd_data    = 32'hDEADBEEF;
        send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4'd0);
        total++;
        if ({cyc, stb, rsp_valid} !== 3'b110 || adr !== 32'h3000_0010) begin
            bad++;
            $display("[TB] FAIL rd_access got=%b/%h want=110/30000010", {cyc, stb, rsp_valid}, adr);
        end
        step();
        total++;
        if ({rsp_valid, rsp_last, rsp_err, stb, cyc, busy} !== 6'b110000 || rsp_dat !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL rd_rsp got=%b/%h want=110000/deadbeef",
                     {rsp_valid, rsp_last, rsp_err, stb, cyc, busy}, rsp_dat);
        end
        step();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_rsp_pulse got=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_write_burst();
        int stb_cnt = 0, cyc_cnt = 0, rsp_cnt = 0;
        slave_wait = 2;
        send_cmd(1'b1, 32'h3000_0000, 32'hA5A5A5A5, 4'h3, 4'd3);
        for (int n = 0; n < 40; n++) begin
            if (cyc) cyc_cnt++;
            if (stb) begin
                stb_cnt++;
                total++;
                if (adr !== 32'h3000_0000 + 32'(4 * rsp_cnt) || dat_o !== 32'hA5A5A5A5 ||
                    sel !== 4'h3 || we !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL wr_beat%0d got=%h/%h/%h/%b want=%h/a5a5a5a5/3/1", rsp_cnt,
                             adr, dat_o, sel, we, 32'h3000_0000 + 32'(4 * rsp_cnt));
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                total++;
                if (rsp_last !== (rsp_cnt == 4) || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL wr_rsp%0d got=last%b err%b %h want=last%b err0 0",
                             rsp_cnt, rsp_last, rsp_err, rsp_dat, rsp_cnt == 4);
                end
                if (rsp_last) break;
            end
            step();
        end
        total++;
        if (rsp_cnt !== 4 || stb_cnt !== 12 || cyc_cnt !== 15) begin
            bad++;
            $display("[TB] FAIL wr_counts got=rsp%0d stb%0d cyc%0d want=rsp4 stb12 cyc15",
                     rsp_cnt, stb_cnt, cyc_cnt);
        end
        total++;
        if (cyc !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_end got=cyc%b busy%b want=cyc0 busy0", cyc, busy);
        end
        step();
    endtask

    task automatic test_timeout();
        int stb_cnt = 0, rsp_cnt = 0;
        slave_wait = 255;
        rd_data    = 32'hCAFEF00D;
        send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 4'd2);
        for (int n = 0; n < 20; n++) begin
            if (stb) stb_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                total++;
                if ({rsp_err, rsp_last, busy, cyc} !== 4'b1100 || rsp_dat !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL to_rsp got=%b/%h want=1100/0", {rsp_err, rsp_last, busy, cyc}, rsp_dat);
                end
            end
            step();
        end
        total++;
        if (stb_cnt !== TO || rsp_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL to_counts got=stb%0d rsp%0d want=stb%0d rsp1", stb_cnt, rsp_cnt, TO);
        end
    endtask

    task automatic test_boundary_ack();
        int stb_cnt = 0, rsp_cnt = 0;
        slave_wait = TO - 1;
        rd_data    = 32'h12345678;
        send_cmd(1'b0, 32'h3000_0080, 32'h0, 4'hF, 4'd0);
        for (int n = 0; n < 20; n++) begin
            if (stb) stb_cnt++;
            if (rsp_valid) begin
                rsp_cnt++;
                total++;
                if ({rsp_err, rsp_last} !== 2'b01 || rsp_dat !== 32'h12345678) begin
                    bad++;
                    $display("[TB] FAIL bnd_rsp got=%b/%h want=01/12345678", {rsp_err, rsp_last}, rsp_dat);
                end
                break;
            end
            step();
        end
        total++;
        if (stb_cnt !== TO || rsp_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL bnd_counts got=stb%0d rsp%0d want=stb%0d rsp1", stb_cnt, rsp_cnt, TO);
        end
        step();
    endtask

    task automatic test_reset_midburst();
        int  rsp_cnt = 0;
        bit  found   = 0;
        slave_wait = 1;
        send_cmd(1'b1, 32'h3000_0100, 32'h11112222, 4'hF, 4'd3);
        for (int n = 0; n < 30; n++) begin
            if (rsp_valid) rsp_cnt++;
            if (rsp_cnt == 1 && stb) begin
                found = 1;
                break;
            end
            step();
        end
        total++;
        if (found !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_reach_beat2 got=%b want=1", found);
        end
        rst_n = 1'b0;
        step();
        total++;
        if ({cyc, stb, we, busy, rsp_valid, rsp_err, rsp_last, cmd_ready} !== 8'b0 ||
            {adr, dat_o, sel, rsp_dat} !== 100'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outs got=%b/%h want=0/0",
                     {cyc, stb, we, busy, rsp_valid, rsp_err, rsp_last, cmd_ready},
                     {adr, dat_o, sel, rsp_dat});
        end
        step();
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL mid_reset_hold got=%b want=00", {cmd_ready, rsp_valid});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_release_ready got=%b want=1", cmd_ready);
        end
        slave_wait = 0;
        rd_data    = 32'h0BADF00D;
        send_cmd(1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'd0);
        step();
        total++;
        if ({rsp_valid, rsp_err, rsp_last} !== 3'b101 || rsp_dat !== 32'h0BADF00D) begin
            bad++;
            $display("[TB] FAIL mid_after_read got=%b/%h want=101/0badf00d",
                     {rsp_valid, rsp_err, rsp_last}, rsp_dat);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] seen [2];
        int stb_cnt = 0, cyc_cnt = 0;
        seen[0] = 32'h1;
        seen[1] = 32'h1;
        slave_wait = 0;
        rd_data    = 32'h55AA55AA;
        send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 4'd1);
        for (int n = 0; n < 20; n++) begin
            if (cyc) cyc_cnt++;
            if (stb) begin
                if (stb_cnt < 2) seen[stb_cnt] = adr;
                stb_cnt++;
            end
            if (rsp_valid && rsp_last) break;
            step();
        end
        total++;
        if (seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL wrap_adr got=%h,%h want=fffffffc,00000000", seen[0], seen[1]);
        end
        total++;
        if (stb_cnt !== 2 || cyc_cnt !== 3) begin
            bad++;
            $display("[TB] FAIL wrap_counts got=stb%0d cyc%0d want=stb2 cyc3", stb_cnt, cyc_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        slave_wait = 0;
        rd_data    = 32'hA0A0A0A0;
        send_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 4'd0);
        step();
        total++;
        if ({rsp_valid, rsp_last, cmd_ready} !== 3'b111) begin
            bad++;
            $display("[TB] FAIL b2b_ready got=%b want=111", {rsp_valid, rsp_last, cmd_ready});
        end
        rd_data = 32'hB1B1B1B1;
        send_cmd(1'b0, 32'h3000_0304, 32'h0, 4'hF, 4'd0);
        total++;
        if (stb !== 1'b1 || adr !== 32'h3000_0304 || rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_accept got=stb%b %h rv%b want=stb1 30000304 rv0", stb, adr, rsp_valid);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_dat !== 32'hB1B1B1B1) begin
            bad++;
            $display("[TB] FAIL b2b_rsp got=%b/%h want=1/b1b1b1b1", rsp_valid, rsp_dat);
        end
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        cmd_len   = 4'h0;
        $display("[TB] starting wb_cmd_master bench");
        test_reset();
        test_single_read();
        test_write_burst();
        test_timeout();
        test_boundary_ack();
        test_reset_midburst();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
